wb_axis_cmd_initiator: RTL
==========================

# wb_axis_cmd_initiator

Host-side initiator for the byte-serial Wishbone bridge protocol. Accepts word-level read/write requests from on-chip logic and serializes them into the command byte stream. Parses the returned byte stream (ACK, read data, status) and reports per-request completion. Sits opposite the AXIS-to-Wishbone bridge across the byte link, or feeds it directly in loopback test fabrics.

## Interface
- ADDR_WIDTH, 32: request address width; serialized as 4 bytes, so it must be 32.
- DATA_WIDTH, 32: word width; fixed at 32 (4 bytes per word).
- RSP_TIMEOUT_CYCLES, 100000: maximum idle cycles allowed while waiting for any response byte.
- One clock; reset is asynchronous and active-high.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid / req_ready  in / out  1 / 1  request handshake.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  start byte address.
- req_len  in  16  word count; 0 is treated as 1.
- wr_data  in  32  write word.
- wr_valid / wr_ready  in / out  1 / 1  write word handshake, one per word.
- rd_data  out  32  read word.
- rd_valid / rd_ready  out / in  1 / 1  read word handshake.
- done  out  1  one-cycle completion pulse.
- status  out  2  valid with done: 0 OK, 1 bridge error (0xFF), 2 timeout, 3 protocol error.
- m_axis_tdata / tvalid / tready / tlast  out / out / in / out  8 / 1 / 1 / 1  command bytes to the bridge.
- s_axis_tdata / tvalid / tready / tlast  in / in / out / in  8 / 1 / 1 / 1  response bytes from the bridge.

## Operation
- Wire format, all multi-byte fields MSB first:
  - Command bytes: opcode (0x00 read, 0x01 write), ADDR[4], LEN[2], one dummy byte 0x00, then for writes LEN×4 data bytes.
  - Bridge replies 0xA5 after the opcode. It ends a write with 0x01 + tlast. It returns LEN×4 read bytes with tlast on the last byte. On error it sends 0xFF + tlast in place of the next expected byte.
- States:
  - IDLE: req_ready=1; on handshake latch write, addr, len (0→1); zero word_cnt and byte_cnt; go to TX_OP.
  - TX_OP: send opcode. Go to WAIT_ACK.
  - WAIT_ACK: accept one byte. 0xA5 → TX_ADDR. Anything else → FINISH with status 3.
  - TX_ADDR: send 4 bytes. Then TX_LEN: send 2 bytes. Then TX_DUMMY: send 0x00, with tlast=1 for reads; then RX_RDATA (read) or WR_FETCH (write).
  - WR_FETCH: wr_ready=1; latch word → TX_WDATA.
  - TX_WDATA: send 4 bytes, tlast on byte 3 of the final word.
    - More words → WR_FETCH; else → RX_STATUS.
    - Bridge error bytes are not checked during the write burst; the bridge stops accepting and emits 0xFF, which RX_STATUS reports.
  - RX_STATUS: accept one byte. 0x01 → status 0. 0xFF → status 1. Other → status 3.
  - RX_RDATA: shift bytes into a word register.
    - tlast on byte 0 of any word with value 0xFF → status 1, FINISH.
    - tlast at any other unexpected position, or missing tlast on the final byte → status 3.
    - After byte 3, assert rd_valid; s_axis_tready=0 until rd_ready.
    - Final word accepted → FINISH with status 0.
  - FINISH: done=1 for one cycle, status valid; → IDLE.
- Timeout:
  - Counter is cleared on every accepted response byte and in non-wait states.
  - It counts in WAIT_ACK, RX_STATUS and RX_RDATA while s_axis_tvalid=0.
  - Reaching RSP_TIMEOUT_CYCLES → FINISH with status 2. Link state is then undefined; the host must reset both ends.
- Widths: word_cnt and len are 16 bits; comparison is word_cnt+1 == len, computed 17-bit (no wrap at 0xFFFF).

## Timing
- Reset values: all tvalid, tlast, tdata = 0; req_ready=1 (IDLE); s_axis_tready=0; wr_ready=0; rd_valid=0; rd_data=0; done=0; status=0.
- m_axis_tvalid/tdata/tlast, s_axis_tready, wr_ready and req_ready are decoded from registered state and counters only; no combinational input→output path.
- First opcode byte is valid the cycle after the req handshake. One byte per cycle while tready=1. tdata is held stable while tvalid && !tready.
- Minimum read of 1 word: 1 + 1 + 4 + 2 + 1 + 4 bytes, plus 1 cycle for the rd handshake and 1 for FINISH.
- done fires exactly once per accepted request, including error and timeout cases.
- Reset mid-operation returns to IDLE immediately; partial words are discarded; no done is issued.

## Structure
- Package wbax_proto_pkg:
  - opcodes CMD_READ/CMD_WRITE;
  - RSP_ACK 0xA5, RSP_SUCCESS 0x01, RSP_ERROR 0xFF;
  - status_t enum;
  - the initiator state_t.
- Sub-module wbax_rsp_timer: clear/enable inputs, expired output, parameterized by RSP_TIMEOUT_CYCLES.

## Test plan
- Write addr 0x1000_0010, len 1, data 0xDEADBEEF → bytes 01,10,00,00,10,00,01,00,DE,AD,BE,EF with tlast on EF; bridge replies A5, 01 → done, status 0.
- Read addr 0x20, len 2; bridge returns 11 22 33 44 55 66 77 88 (tlast on 88) → rd_data 0x11223344 then 0x55667788, status 0; hold rd_ready low 5 cycles → s_axis_tready stays low, no byte lost.
- Read len 3; bridge sends word 0, then FF+tlast → one rd word, done with status 1.
- Bridge replies 0x5A instead of A5 → done with status 3; no address bytes sent.
- RSP_TIMEOUT_CYCLES=16; bridge silent after ACK in a write → done with status 2 exactly 16 cycles after entering RX_STATUS.
- Assert rst during TX_ADDR byte 2 → all outputs at reset values next cycle; a new request then completes normally.

Source files
------------

// File: rtl/wbax_proto_pkg.sv
// Shared wire-protocol constants and types for the byte-serial Wishbone bridge link.
package wbax_proto_pkg;

  localparam logic [7:0] CMD_READ    = 8'h00;
  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] RSP_ACK     = 8'hA5;
  localparam logic [7:0] RSP_SUCCESS = 8'h01;
  localparam logic [7:0] RSP_ERROR   = 8'hFF;

  typedef enum logic [1:0] {
    ST_OK         = 2'd0,
    ST_BRIDGE_ERR = 2'd1,
    ST_TIMEOUT    = 2'd2,
    ST_PROTO_ERR  = 2'd3
  } status_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TX_OP,
    S_WAIT_ACK,
    S_TX_ADDR,
    S_TX_LEN,
    S_TX_DUMMY,
    S_WR_FETCH,
    S_TX_WDATA,
    S_RX_STATUS,
    S_RX_RDATA,
    S_FINISH
  } state_t;

  // Byte idx of a 32-bit word in wire order (idx 0 is the MSB).
  function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/wbax_rsp_timer.sv
// Response watchdog: counts enabled idle cycles, flags expiry on the last allowed one.
module wbax_rsp_timer
  import wbax_proto_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(RSP_TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(RSP_TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Expiry is combinational so the FSM leaves on the Nth idle cycle, not N+1.
  assign expired = enable && (cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_axis_cmd_initiator.sv
// Host-side initiator: serializes word read/write requests into bridge command bytes
// and parses ACK / read data / status bytes back into per-request completions.
module wb_axis_cmd_initiator
  import wbax_proto_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned RSP_TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            status,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast
);

  state_t                state;
  status_t               status_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           len_q;
  logic [15:0]           word_cnt;
  logic [1:0]            byte_cnt;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [23:0]           word_sr;
  logic                  last_word;
  logic                  wait_st;
  logic                  rsp_accept;
  logic                  tmr_clear;
  logic                  tmr_enable;
  logic                  expired;

  assign status    = status_q;
  assign last_word = ({1'b0, word_cnt} + 17'd1) == {1'b0, len_q};

  assign wait_st    = (state == S_WAIT_ACK) || (state == S_RX_STATUS) || (state == S_RX_RDATA);
  assign rsp_accept = s_axis_tvalid && s_axis_tready;
  assign tmr_clear  = !wait_st || rsp_accept;
  // A read word parked for the consumer is not a bridge stall.
  assign tmr_enable = wait_st && !s_axis_tvalid && !rd_valid;

  wbax_rsp_timer #(
    .RSP_TIMEOUT_CYCLES(RSP_TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(expired)
  );

  always_comb begin
    req_ready     = 1'b0;
    wr_ready      = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    case (state)
      S_IDLE:      req_ready = 1'b1;
      S_TX_OP: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = write_q ? CMD_WRITE : CMD_READ;
      end
      S_WAIT_ACK,
      S_RX_STATUS: s_axis_tready = 1'b1;
      S_TX_ADDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = be_byte(addr_q, byte_cnt);
      end
      S_TX_LEN: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = (byte_cnt == 2'd0) ? len_q[15:8] : len_q[7:0];
      end
      S_TX_DUMMY: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = !write_q;
      end
      S_WR_FETCH:  wr_ready = 1'b1;
      S_TX_WDATA: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = be_byte(wdata_q, byte_cnt);
        m_axis_tlast  = (byte_cnt == 2'd3) && last_word;
      end
      S_RX_RDATA:  s_axis_tready = !rd_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      status_q <= ST_OK;
      done     <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      wdata_q  <= '0;
      word_sr  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            addr_q   <= req_addr;
            len_q    <= (req_len == 16'd0) ? 16'd1 : req_len;
            word_cnt <= '0;
            byte_cnt <= '0;
            state    <= S_TX_OP;
          end
        end
        S_TX_OP: begin
          if (m_axis_tready) state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (s_axis_tvalid) begin
            if (s_axis_tdata == RSP_ACK) begin
              state <= S_TX_ADDR;
            end else begin
              state <= S_FINISH; done <= 1'b1; status_q <= ST_PROTO_ERR;
            end
          end else if (expired) begin
            state <= S_FINISH; done <= 1'b1; status_q <= ST_TIMEOUT;
          end
        end
        S_TX_ADDR: begin
          if (m_axis_tready) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= S_TX_LEN;
          end
        end
        S_TX_LEN: begin
          if (m_axis_tready) begin
            if (byte_cnt == 2'd1) begin
              byte_cnt <= '0;
              state    <= S_TX_DUMMY;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        S_TX_DUMMY: begin
          if (m_axis_tready) state <= write_q ? S_WR_FETCH : S_RX_RDATA;
        end
        S_WR_FETCH: begin
          if (wr_valid) begin
            wdata_q <= wr_data;
            state   <= S_TX_WDATA;
          end
        end
        S_TX_WDATA: begin
          if (m_axis_tready) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (last_word) begin
                state <= S_RX_STATUS;
              end else begin
                word_cnt <= word_cnt + 16'd1;
                state    <= S_WR_FETCH;
              end
            end
          end
        end
        S_RX_STATUS: begin
          if (s_axis_tvalid) begin
            state <= S_FINISH;
            done  <= 1'b1;
            if (s_axis_tdata == RSP_SUCCESS)    status_q <= ST_OK;
            else if (s_axis_tdata == RSP_ERROR) status_q <= ST_BRIDGE_ERR;
            else                                status_q <= ST_PROTO_ERR;
          end else if (expired) begin
            state <= S_FINISH; done <= 1'b1; status_q <= ST_TIMEOUT;
          end
        end
        S_RX_RDATA: begin
          if (rd_valid) begin
            if (rd_ready) begin
              rd_valid <= 1'b0;
              if (last_word) begin
                state <= S_FINISH; done <= 1'b1; status_q <= ST_OK;
              end else begin
                word_cnt <= word_cnt + 16'd1;
              end
            end
          end else if (s_axis_tvalid) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_sr  <= {word_sr[15:0], s_axis_tdata};
            // tlast is only legal on the final data byte or on an error byte at a word boundary.
            if (s_axis_tlast && byte_cnt == 2'd0 && s_axis_tdata == RSP_ERROR) begin
              state <= S_FINISH; done <= 1'b1; status_q <= ST_BRIDGE_ERR;
            end else if (byte_cnt == 2'd3) begin
              if (s_axis_tlast != last_word) begin
                state <= S_FINISH; done <= 1'b1; status_q <= ST_PROTO_ERR;
              end else begin
                rd_data  <= {word_sr, s_axis_tdata};
                rd_valid <= 1'b1;
              end
            end else if (s_axis_tlast) begin
              state <= S_FINISH; done <= 1'b1; status_q <= ST_PROTO_ERR;
            end
          end else if (expired) begin
            state <= S_FINISH; done <= 1'b1; status_q <= ST_TIMEOUT;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
